// File: rtl/add_arb_pkg.sv
// Shared types and helpers for the add_arb shared-adder controller.
package add_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int WIDTH_DEF = 16;

  // Width needed to index n items, never narrower than one bit.
  function automatic int id_w(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/add_arb_add16_rca.sv
// Combinational ripple-carry adder shared by all add_arb requesters.
module add16_rca #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  logic carry;

  // A scalar carry chained through the loop keeps the ripple explicit.
  always_comb begin
    carry = cin;
    s     = '0;
    for (int i = 0; i < WIDTH; i++) begin
      s[i]  = a[i] ^ b[i] ^ carry;
      carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/add_arb.sv
// Round-robin arbiter time-sharing one ripple-carry adder between N_REQ requesters.
// Define ADD_ARB_SUB_EN to add the per-requester req_sub (subtract) input.
module add_arb
  import add_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = WIDTH_DEF,
  parameter int ADD_LAT = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ*WIDTH-1:0]    req_a,
  input  logic [N_REQ*WIDTH-1:0]    req_b,
  input  logic [N_REQ-1:0]          req_cin,
`ifdef ADD_ARB_SUB_EN
  input  logic [N_REQ-1:0]          req_sub,
`endif
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [id_w(N_REQ)-1:0]    rsp_id,
  output logic [WIDTH-1:0]          rsp_sum,
  output logic                      rsp_cout
);

  localparam int IDW   = id_w(N_REQ);
  localparam int CNT_W = id_w(ADD_LAT);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ADD_LAT - 1);

  state_t           state;
  logic [IDW-1:0]   rr_ptr;
  logic [CNT_W-1:0] cnt;
  logic [IDW-1:0]   op_id;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_cin;

  logic             grant_ok;
  logic [IDW-1:0]   grant_idx;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic             sel_cin;

  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic [WIDTH-1:0] add_s;
  logic             add_cout;

  // First valid requester at or after rr_ptr, wrapping around.
  always_comb begin
    int idx;
    idx       = 0;
    grant_ok  = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (!grant_ok && req_valid[idx]) begin
        grant_ok  = 1'b1;
        grant_idx = IDW'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && grant_ok && !rst) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_cin = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (IDW'(i) == grant_idx) begin
        sel_a   = req_a[i*WIDTH +: WIDTH];
        sel_b   = req_b[i*WIDTH +: WIDTH];
        sel_cin = req_cin[i];
      end
    end
  end

`ifdef ADD_ARB_SUB_EN
  logic op_sub;
  logic sel_sub;

  always_comb begin
    sel_sub = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (IDW'(i) == grant_idx) sel_sub = req_sub[i];
    end
  end

  // Subtraction is a + ~b + 1, so cout=1 means no borrow.
  assign add_b   = op_sub ? ~op_b : op_b;
  assign add_cin = op_sub | op_cin;

  always_ff @(posedge clk) begin
    if (rst) op_sub <= 1'b0;
    else if (state == IDLE && grant_ok) op_sub <= sel_sub;
  end
`else
  assign add_b   = op_b;
  assign add_cin = op_cin;
`endif

  add16_rca #(.WIDTH(WIDTH)) u_rca (
    .a    (op_a),
    .b    (add_b),
    .cin  (add_cin),
    .s    (add_s),
    .cout (add_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      cnt       <= '0;
      op_id     <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_cin    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
      rsp_id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_ok) begin
            op_a   <= sel_a;
            op_b   <= sel_b;
            op_cin <= sel_cin;
            op_id  <= grant_idx;
            cnt    <= CNT_INIT;
            state  <= ADD;
          end
        end
        ADD: begin
          // Operands stay on the adder for ADD_LAT cycles before sampling.
          if (cnt == '0) begin
            rsp_sum   <= add_s;
            rsp_cout  <= add_cout;
            rsp_id    <= op_id;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rr_ptr    <= (rsp_id == IDW'(N_REQ - 1)) ? '0 : rsp_id + 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_add_arb.sv
// Directed scoreboard bench for add_arb; subtract cases run when ADD_ARB_SUB_EN is defined.
module tb_add_arb;
  import add_arb_pkg::*;

  localparam int N   = 4;
  localparam int W   = 16;
  localparam int LAT = 2;

  typedef struct {
    int           id;
    logic [W-1:0] sum;
    logic         cout;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_cin;
`ifdef ADD_ARB_SUB_EN
  logic [N-1:0]   req_sub;
`endif
  logic           rsp_valid;
  logic           rsp_ready;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_sum;
  logic           rsp_cout;

  logic [W-1:0] a_arr [N];
  logic [W-1:0] b_arr [N];
  logic         cin_arr [N];
  logic         sub_arr [N];

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   t_acc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = a_arr[i];
      req_b[i*W +: W] = b_arr[i];
      req_cin[i]      = cin_arr[i];
`ifdef ADD_ARB_SUB_EN
      req_sub[i]      = sub_arr[i];
`endif
    end
  end

  add_arb #(.N_REQ(N), .WIDTH(W), .ADD_LAT(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
`ifdef ADD_ARB_SUB_EN
    .req_sub   (req_sub),
`endif
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout)
  );

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic cin, input logic sub);
    if (sub) return {1'b0, a} + {1'b0, ~b} + 17'd1;
    return {1'b0, a} + {1'b0, b} + 17'(cin);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic report_timeout(input string tag);
    checks++;
    failures++;
    $error("[TB] FAIL %s observed=timeout expected=handshake", tag);
  endtask

  task automatic apply_stimulus(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic cin, input logic sub);
    a_arr[i]     = a;
    b_arr[i]     = b;
    cin_arr[i]   = cin;
    sub_arr[i]   = sub;
    req_valid[i] = 1'b1;
  endtask

  // Waits for a grant, pushes the model result, returns just after the transfer edge.
  task automatic do_accept(output int gid);
    bit   done;
    exp_t e;
    done = 1'b0;
    gid  = -1;
    for (int n = 0; n < 40 && !done; n++) begin
      #1;
      if (req_ready != '0) begin
        done = 1'b1;
        check("ready_onehot", 32'($countones(req_ready)), 32'd1);
        for (int i = 0; i < N; i++) if (req_ready[i]) gid = i;
        t_acc = cyc;
        e.id = gid;
        {e.cout, e.sum} = model(a_arr[gid], b_arr[gid], cin_arr[gid], sub_arr[gid]);
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
      end else begin
        @(negedge clk);
      end
    end
    if (!done) report_timeout("accept_timeout");
  endtask

  task automatic check_output(input int hold, output int seen);
    bit   got;
    exp_t e;
    got  = 1'b0;
    seen = -1;
    for (int n = 0; n < 40 && !got; n++) begin
      if (rsp_valid) got = 1'b1;
      else @(negedge clk);
    end
    if (!got) begin
      report_timeout("rsp_timeout");
      return;
    end
    seen = cyc;
    if (sb.size() == 0) begin
      check("rsp_unexpected", 32'(rsp_valid), 32'd0);
      return;
    end
    e = sb.pop_front();
    check("rsp_id", 32'(rsp_id), 32'(e.id));
    check("rsp_sum", 32'(rsp_sum), 32'(e.sum));
    check("rsp_cout", 32'(rsp_cout), 32'(e.cout));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_id", 32'(rsp_id), 32'(e.id));
      check("hold_sum", 32'(rsp_sum), 32'(e.sum));
      check("hold_cout", 32'(rsp_cout), 32'(e.cout));
      check("hold_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_drop", 32'(rsp_valid), 32'd0);
  endtask

  task automatic run_one(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub);
    int gid;
    int seen;
    apply_stimulus(i, a, b, cin, sub);
    do_accept(gid);
    check("grant_id", 32'(gid), 32'(i));
    req_valid[i] = 1'b0;
    check_output(0, seen);
  endtask

  initial begin
    int gid;
    int seen;
    rst       = 1'b1;
    rsp_ready = 1'b0;
    req_valid = '0;
    for (int i = 0; i < N; i++) begin
      a_arr[i] = '0; b_arr[i] = '0; cin_arr[i] = 1'b0; sub_arr[i] = 1'b0;
    end
    apply_stimulus(0, 16'd5, 16'd6, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_sum", 32'(rsp_sum), 32'd0);
    check("reset_rsp_cout", 32'(rsp_cout), 32'd0);
    check("reset_rsp_id", 32'(rsp_id), 32'd0);
    check("reset_req_ready", 32'(req_ready), 32'd0);
    req_valid = '0;
    rst = 1'b0;
    @(negedge clk);
    check("idle_no_ready", 32'(req_ready), 32'd0);

    $display("[TB] single add with latency");
    apply_stimulus(0, 16'd20, 16'd30, 1'b0, 1'b0);
    do_accept(gid);
    check("single_grant", 32'(gid), 32'd0);
    req_valid[0] = 1'b0;
    check_output(0, seen);
    check("single_latency", 32'(seen), 32'(t_acc + LAT + 1));

    $display("[TB] overflow");
    run_one(0, 16'hFFFF, 16'd1, 1'b0, 1'b0);
    run_one(0, 16'hFFFF, 16'd0, 1'b1, 1'b0);

    $display("[TB] round robin from reset");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N; i++) apply_stimulus(i, 16'(i), 16'd100, 1'b0, 1'b0);
    for (int k = 0; k < N; k++) begin
      do_accept(gid);
      check("rr_order", 32'(gid), 32'(k));
      if (gid > 0) req_valid[gid] = 1'b0;
      check_output(0, seen);
    end
    do_accept(gid);
    check("rr_wrap", 32'(gid), 32'd0);
    req_valid[0] = 1'b0;
    check_output(0, seen);

    $display("[TB] backpressure");
    apply_stimulus(2, 16'd1234, 16'd4321, 1'b1, 1'b0);
    do_accept(gid);
    check("bp_grant", 32'(gid), 32'd2);
    req_valid[2] = 1'b0;
    apply_stimulus(1, 16'd5, 16'd6, 1'b0, 1'b0);
    check_output(5, seen);
    do_accept(gid);
    check("bp_second_grant", 32'(gid), 32'd1);
    req_valid[1] = 1'b0;
    check_output(0, seen);

    $display("[TB] reset mid-operation");
    apply_stimulus(2, 16'd7, 16'd8, 1'b0, 1'b0);
    do_accept(gid);
    check("abort_grant", 32'(gid), 32'd2);
    req_valid[2] = 1'b0;
    rst = 1'b1;
    apply_stimulus(3, 16'd300, 16'd3, 1'b0, 1'b0);
    apply_stimulus(1, 16'd40, 16'd2, 1'b1, 1'b0);
    if (sb.size() > 0) void'(sb.pop_back());
    @(negedge clk);
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort_ready_in_rst", 32'(req_ready), 32'd0);
    check("abort_state", 32'(int'(dut.state)), 32'(int'(IDLE)));
    rst = 1'b0;
    do_accept(gid);
    check("post_reset_ptr", 32'(gid), 32'd1);
    req_valid[1] = 1'b0;
    check_output(0, seen);
    do_accept(gid);
    check("post_reset_next", 32'(gid), 32'd3);
    req_valid[3] = 1'b0;
    check_output(0, seen);

    $display("[TB] random single requests");
    for (int n = 0; n < 6; n++) begin
      run_one(int'($urandom_range(0, N - 1)), 16'($urandom), 16'($urandom),
              1'($urandom_range(0, 1)), 1'b0);
    end

`ifdef ADD_ARB_SUB_EN
    $display("[TB] subtract");
    run_one(0, 16'd321, 16'd123, 1'b0, 1'b1);
    run_one(2, 16'd1, 16'd2, 1'b1, 1'b1);
`endif

    repeat (4) @(negedge clk);
    check("no_stray_rsp", 32'(rsp_valid), 32'd0);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
